// File: rtl/change_dispenser.sv
// Vending output stage: vends on every cycle with deposit >= PRICE, queues the
// excess as nickel credits, and pays change out one coin per cycle (dimes first).
module change_dispenser #(
  parameter int PRICE  = 20,
  parameter int DEP_W  = 6,
  parameter int PEND_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DEP_W-1:0] deposit_i,
  output logic             soda_o,
  output logic             dime_o,
  output logic             nickle_o,
  output logic             busy_o,
  output logic             change_ovf_o
);

  localparam logic [DEP_W-1:0] PRICE_D = DEP_W'(PRICE);
  localparam logic [DEP_W-1:0] FIVE_D  = DEP_W'(5);

  logic [PEND_W-1:0] r_pend;
  logic              r_soda;
  logic              r_dime;
  logic              r_nickle;
  logic              r_ovf;

  logic              w_vend;
  logic [DEP_W-1:0]  w_excess;
  logic [DEP_W-1:0]  w_add_dep;
  logic [PEND_W:0]   w_add;
  logic              w_dime;
  logic              w_nickle;
  logic [PEND_W:0]   w_sub;
  logic [PEND_W:0]   w_sum;

  // Clamp the one-bit-wider running sum back into the counter range.
  function automatic logic [PEND_W-1:0] sat_pend(input logic [PEND_W:0] s);
    if (s[PEND_W]) return '1;
    else           return s[PEND_W-1:0];
  endfunction

  function automatic logic sat_hit(input logic [PEND_W:0] s);
    return s[PEND_W];
  endfunction

  // Level-sensitive vend: every cycle at or above price is its own sale.
  assign w_vend    = (deposit_i >= PRICE_D);
  assign w_excess  = w_vend ? (deposit_i - PRICE_D) : '0;
  assign w_add_dep = w_excess / FIVE_D;
  assign w_add     = (PEND_W+1)'(w_add_dep);

  always_comb begin
    w_dime   = 1'b0;
    w_nickle = 1'b0;
    w_sub    = '0;
    if (r_pend > PEND_W'(1)) begin
      w_dime = 1'b1;
      w_sub  = (PEND_W+1)'(2);
    end else if (r_pend == PEND_W'(1)) begin
      w_nickle = 1'b1;
      w_sub    = (PEND_W+1)'(1);
    end
  end

  // sub never exceeds pend, so the subtraction cannot wrap.
  assign w_sum = {1'b0, r_pend} - w_sub + w_add;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend   <= '0;
      r_soda   <= 1'b0;
      r_dime   <= 1'b0;
      r_nickle <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_pend   <= sat_pend(w_sum);
      r_soda   <= w_vend;
      r_dime   <= w_dime;
      r_nickle <= w_nickle;
      if (sat_hit(w_sum)) r_ovf <= 1'b1;
    end
  end

  assign soda_o       = r_soda;
  assign dime_o       = r_dime;
  assign nickle_o     = r_nickle;
  assign change_ovf_o = r_ovf;
  assign busy_o       = (r_pend != '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboarded directed bench for change_dispenser: a default instance and a
// PEND_W=2 instance that exercises change saturation.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic [5:0] dep_a;
  logic [5:0] dep_b;
  logic       soda_a, dime_a, nick_a, busy_a, ovf_a;
  logic       soda_b, dime_b, nick_b, busy_b, ovf_b;

  change_dispenser #(.PRICE(20), .DEP_W(6), .PEND_W(6)) dut_a (
    .clk_i(clk), .rst_i(rst), .deposit_i(dep_a),
    .soda_o(soda_a), .dime_o(dime_a), .nickle_o(nick_a),
    .busy_o(busy_a), .change_ovf_o(ovf_a)
  );

  change_dispenser #(.PRICE(20), .DEP_W(6), .PEND_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .deposit_i(dep_b),
    .soda_o(soda_b), .dime_o(dime_b), .nickle_o(nick_b),
    .busy_o(busy_b), .change_ovf_o(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       id;
    logic [4:0] ea;
    logic [4:0] eb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   row = 0;
  bit   done = 0;

  // Expected outputs {soda,dime,nickle,busy,ovf} after the edge sampling this row.
  task automatic step(input logic r, input logic [5:0] da, input logic [5:0] db,
                      input logic [4:0] ea, input logic [4:0] eb);
    exp_t e;
    @(negedge clk);
    rst   = r;
    dep_a = da;
    dep_b = db;
    e.id = row;
    e.ea = ea;
    e.eb = eb;
    q.push_back(e);
    row++;
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] ga, gb;
      e  = q.pop_front();
      ga = {soda_a, dime_a, nick_a, busy_a, ovf_a};
      gb = {soda_b, dime_b, nick_b, busy_b, ovf_b};
      n_checks++;
      if (ga !== e.ea) begin
        n_errors++;
        $display("FAIL row%0d dut_a {soda,dime,nick,busy,ovf} got=%b exp=%b", e.id, ga, e.ea);
      end
      n_checks++;
      if (gb !== e.eb) begin
        n_errors++;
        $display("FAIL row%0d dut_b {soda,dime,nick,busy,ovf} got=%b exp=%b", e.id, gb, e.eb);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    dep_a = '0;
    dep_b = '0;
    // reset state
    step(1, 0, 0, 5'b00000, 5'b00000);
    step(1, 0, 0, 5'b00000, 5'b00000);
    // below price: nothing happens
    for (int i = 0; i < 5; i++) step(0, 15, 0, 5'b00000, 5'b00000);
    // exact price: soda only
    step(0, 20, 0, 5'b10000, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // 40: four nickels of change paid as two dimes
    step(0, 40, 0, 5'b10010, 5'b00000);
    step(0,  0, 0, 5'b01010, 5'b00000);
    step(0,  0, 0, 5'b01000, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // 35 then 25: vend and payout in the same edge
    step(0, 35, 0, 5'b10010, 5'b00000);
    step(0, 25, 0, 5'b11010, 5'b00000);
    step(0,  0, 0, 5'b01000, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // 25: single nickel
    step(0, 25, 0, 5'b10010, 5'b00000);
    step(0,  0, 0, 5'b00100, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // consecutive vends at price
    step(0, 20, 0, 5'b10000, 5'b00000);
    step(0, 20, 0, 5'b10000, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // non-multiple deposits: remainder truncated
    step(0, 27, 0, 5'b10010, 5'b00000);
    step(0, 24, 0, 5'b10100, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // reset mid-payout drops the pending change
    step(0, 40, 0, 5'b10010, 5'b00000);
    step(1,  0, 0, 5'b00000, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    step(0,  0, 0, 5'b00000, 5'b00000);
    // saturation on the PEND_W=2 instance: clamp to 3, dime then nickel
    step(0, 0, 40, 5'b00000, 5'b10011);
    step(0, 0,  0, 5'b00000, 5'b01011);
    step(0, 0,  0, 5'b00000, 5'b00101);
    step(0, 0,  0, 5'b00000, 5'b00001);
    step(0, 0,  0, 5'b00000, 5'b00001);
    // sticky overflow cleared only by reset
    step(1, 0,  0, 5'b00000, 5'b00000);
    step(0, 0,  0, 5'b00000, 5'b00000);
    begin
      int budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (q.size() > 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain pending=%0d required=0", q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
